// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial WIDTH-bit add/sub, DIGIT bits per cycle, start/busy/done handshake
// ports: clk, rst (sync, active-high), start, m (0 add / 1 sub), a, b -> busy, done, S, CoBo, ovf, zero
// option: define SERIAL_ADDSUB_SAT_EN to saturate S on signed overflow (flags stay raw)
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             m,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             CoBo,
  output logic             ovf,
  output logic             zero
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] ra, rb, acc, acc_n, res;
  logic [CW-1:0] cnt;
  logic [DIGIT:0] dsum;
  logic carry, last, load, ovf_n;
  assign dsum  = {1'b0, ra[DIGIT-1:0]} + {1'b0, rb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  assign acc_n = (acc >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
  assign last  = state == RUN && cnt == CW'(N - 1);
  assign load  = start && state != RUN;
  // in the final digit ra/rb bit DIGIT-1 are the operand sign bits
  assign ovf_n = ra[DIGIT-1] == rb[DIGIT-1] && dsum[DIGIT-1] != ra[DIGIT-1];
`ifdef SERIAL_ADDSUB_SAT_EN
  assign res = ovf_n ? {ra[DIGIT-1], {(WIDTH-1){~ra[DIGIT-1]}}} : acc_n;
`else
  assign res = acc_n;
`endif
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    state_n = load ? RUN : last ? DONE : state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ra    <= '0;
      rb    <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      CoBo  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else if (load) begin
      ra    <= a;
      rb    <= b ^ {WIDTH{m}};
      carry <= m;
      cnt   <= '0;
    end else if (state == RUN) begin
      ra    <= ra >> DIGIT;
      rb    <= rb >> DIGIT;
      acc   <= acc_n;
      carry <= dsum[DIGIT];
      cnt   <= cnt + CW'(1);
      if (last) begin
        S    <= res;
        CoBo <= dsum[DIGIT];
        ovf  <= ovf_n;
        zero <= res == '0;
      end
    end
  end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Multi-cycle, parametrised N-bit adder/subtractor. It processes DIGIT bits per clock through a registered carry/borrow chain. It succeeds the fixed-width combinational parallel add/sub stage, trading latency for area. It adds a start/busy/done handshake and result flags for use by datapath controllers.

Parameters:
WIDTH, 8, operand/result width in bits; must be ≥ 2.
DIGIT, 2, bits processed per cycle; must divide WIDTH; DIGIT = WIDTH gives single-cycle operation.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  request a new operation; sampled on clk.
m  input  1  mode: 0 = add (a+b), 1 = subtract (a-b); captured with start.
a  input  WIDTH  operand A; captured with start.
b  input  WIDTH  operand B; captured with start.
busy  output  1  operation in progress.
done  output  1  one-cycle pulse; result valid.
S  output  WIDTH  sum/difference.
CoBo  output  1  final carry-out; in subtract mode 1 = no borrow (a ≥ b unsigned).
ovf  output  1  two's-complement signed overflow.
zero  output  1  S == 0.

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst.
- Reset values: state IDLE; busy, done, S, CoBo, ovf and zero all 0. Internal operand, carry and digit-counter registers are cleared.
- FSM states:
  - IDLE: start=1 → load operands, go to RUN.
  - RUN: processes one digit per edge; after N = WIDTH/DIGIT digits → DONE.
  - DONE: lasts one cycle; start=1 → load and go to RUN (back-to-back allowed); otherwise → IDLE.
- Load on an accepted start:
  - capture a, b and m;
  - effective B = b XOR {WIDTH{m}};
  - carry register = m;
  - digit counter = 0.
- Each RUN cycle:
  - add the low DIGIT bits of A, effective B and carry;
  - shift the DIGIT sum bits into the result register from the MSB side;
  - shift the operand registers right by DIGIT;
  - store carry-out; increment the counter.
- Latency: start sampled high at edge k → busy=1 from edge k through edge k+N-1; done=1 and busy=0 in the cycle after edge k+N.
- Output stability:
  - S, CoBo, ovf and zero update only when done is asserted.
  - They hold their values until the next done; they are not changed by intermediate RUN cycles.
- Flags:
  - CoBo = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = (final S == 0).
- start while busy=1: ignored. No queuing, and the captured operands are unaffected.
- a, b and m are don't-care except in the cycle start is accepted.
- rst during RUN: aborts the operation. The next cycle is IDLE with all outputs 0, and no done pulse is produced.
- rst and start in the same cycle: rst wins.
- Arithmetic is modulo 2^WIDTH; overflow never extends the S width.

Optional Feature:
Macro SERIAL_ADDSUB_SAT_EN.
- Defined: when ovf=1, S is replaced by the signed saturation value.
  - Positive overflow (operand sign bits indicate a positive result) → S = 0111…1.
  - Negative overflow → S = 1000…0.
  - ovf and CoBo still report the raw flags; zero is computed on the saturated S.
  - Saturation is applied at the DONE transition and adds no latency.
- Undefined: S is the raw wrapped result. No saturation logic is synthesised.

Test Plan:
WIDTH=8, DIGIT=2 unless stated.
1. m=1, a=8'h03, b=8'h01, start pulse → done exactly 4 cycles after the start edge; S=8'h02, CoBo=1, ovf=0, zero=0.
2. m=1, a=8'h02, b=8'h03 → S=8'hFF, CoBo=0 (borrow), ovf=0; then m=0, a=8'hFF, b=8'h01 started in the DONE cycle → back-to-back accepted; S=8'h00, CoBo=1, zero=1.
3. m=0, a=8'h7F, b=8'h01 → ovf=1. Without SAT_EN: S=8'h80. With SERIAL_ADDSUB_SAT_EN: S=8'h7F. Also m=1, a=8'h80, b=8'h01 → ovf=1; S=8'h7F raw, or S=8'h80 saturated.
4. Start m=0, a=8'h10, b=8'h20; pulse start with a=8'hAA in the 2nd busy cycle → ignored; result S=8'h30, done only once.
5. Start an operation, assert rst on the 2nd busy cycle → next cycle busy=0, S=0, flags=0, no done pulse; a new start then completes normally.
6. Parameter sweep with DIGIT=1, 4 and 8 (WIDTH=8) → latency 8, 2 and 1 cycles respectively; a randomized 1000-operation run matches a reference (a±b) mod 256 together with the CoBo, ovf and zero flags.
